wb_trace_buffer: RTL and testbench

//   Parametrised successor to the single-issue debug_wb_* trace tap. Captures write-back

---
 rtl/wb_trace_buffer_pkg.sv | 23 ++
 rtl/wb_trace_buffer_fifo.sv | 51 +++++
 rtl/wb_trace_buffer.sv | 82 ++++++++
 tb/tb_wb_trace_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: FSM encodings,
// record layout helpers and event qualification.
package wb_trace_buffer_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_FROZEN  = 2'd3;

   // Record layout, MSB to LSB: {pc, ena, reg, value}
   function automatic int rec_w(input int xlen);
      return 2 * xlen + 1 + REG_W;
   endfunction

   // With the write-only filter on, only real register-file writes count
   function automatic logic is_qual(input logic have_inst, input logic wr_only,
                                    input logic ena, input logic [REG_W-1:0] rd);
      return have_inst && (!wr_only || (ena && (rd != '0)));
   endfunction

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO without a
// pop overwrites the oldest entry; the caller suppresses the push when it
// wants drop semantics instead. Output data reads as zero while empty.
module wb_trace_buffer_fifo #(
   parameter int WIDTH = 70,
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_ok;
   logic             ovw;

   assign full   = (count == CNT_W'(DEPTH));
   assign pop_ok = pop && (count != '0);
   assign ovw    = push && full && !pop_ok;
   assign dout   = (count != '0) ? mem[rd_ptr] : '0;

   // Storage write; contents need no reset because dout is gated while empty
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy update; overwrite advances both pointers together
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok || ovw) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop_ok && !full) count <= count + CNT_W'(1);
         else if (pop_ok && !push)     count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: qualifies retire events, waits for an optional
// PC trigger, and feeds a FWFT buffer that drains over valid/ready.
module wb_trace_buffer
   import wb_trace_buffer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_have_inst,
   input  logic [XLEN-1:0]  wb_pc,
   input  logic             wb_ena,
   input  logic [REG_W-1:0] wb_reg,
   input  logic [XLEN-1:0]  wb_value,
   input  logic             cfg_wr_only,
   input  logic             cfg_wrap,
   input  logic             cfg_trig_en,
   input  logic [XLEN-1:0]  cfg_trig_pc,
   input  logic             arm,
   input  logic             stop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic             out_ena,
   output logic [REG_W-1:0] out_reg,
   output logic [XLEN-1:0]  out_value,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic [1:0]       state
);

   localparam int REC_W = rec_w(XLEN);

   logic             qual, hit, arm_go, push_req, pop, full, drop, ovw;
   logic [REC_W-1:0] rec_in, rec_out;

   assign qual   = is_qual(wb_have_inst, cfg_wr_only, wb_ena, wb_reg);
   assign hit    = qual && (wb_pc == cfg_trig_pc);
   // stop beats arm, so a simultaneous arm neither flushes nor re-arms
   assign arm_go = arm && !stop;
   // Events in the arm cycle are never recorded: the buffer is being flushed
   assign push_req = !arm_go && (((state == ST_CAPTURE) && qual) ||
                                 ((state == ST_ARMED) && hit));
   assign pop  = out_valid && out_ready;
   assign drop = push_req && full && !pop && !cfg_wrap;
   assign ovw  = push_req && full && !pop && cfg_wrap;

   assign rec_in    = {wb_pc, wb_ena, wb_reg, wb_value};
   assign out_valid = (count != '0);
   assign {out_pc, out_ena, out_reg, out_value} = rec_out;

   wb_trace_buffer_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (arm_go),
      .push  (push_req && !drop),
      .pop   (pop),
      .din   (rec_in),
      .dout  (rec_out),
      .count (count),
      .full  (full)
   );

   // Capture FSM: stop first, then arm, then drop-to-freeze and trigger hit
   always_ff @(posedge clk) begin
      if (!rst_n)                           state <= ST_IDLE;
      else if (stop)                        state <= ST_IDLE;
      else if (arm)                         state <= cfg_trig_en ? ST_ARMED : ST_CAPTURE;
      else if (drop)                        state <= ST_FROZEN;
      else if ((state == ST_ARMED) && hit)  state <= ST_CAPTURE;
   end

   // Sticky loss flag, cleared only by a fresh arm
   always_ff @(posedge clk) begin
      if (!rst_n)            overflow <= 1'b0;
      else if (arm_go)       overflow <= 1'b0;
      else if (drop || ovw)  overflow <= 1'b1;
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=4): trigger, filter, stop/wrap
// overflow handling, full-throughput streaming and mid-stream reset.
module tb_wb_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n, wb_have_inst, wb_ena, cfg_wr_only, cfg_wrap, cfg_trig_en;
   logic        arm, stop, out_valid, out_ready, out_ena, overflow;
   logic [31:0] wb_pc, wb_value, cfg_trig_pc, out_pc, out_value;
   logic [4:0]  wb_reg, out_reg;
   logic [2:0]  count;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   wb_trace_buffer #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
      .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
      .cfg_wr_only(cfg_wr_only), .cfg_wrap(cfg_wrap), .cfg_trig_en(cfg_trig_en),
      .cfg_trig_pc(cfg_trig_pc), .arm(arm), .stop(stop), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_ena(out_ena), .out_reg(out_reg),
      .out_value(out_value), .count(count), .overflow(overflow), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ev(input logic [31:0] pc, input logic en, input logic [4:0] rg,
                     input logic [31:0] v);
      wb_have_inst = 1'b1; wb_pc = pc; wb_ena = en; wb_reg = rg; wb_value = v;
      tick();
      wb_have_inst = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wb_have_inst = 1'b0; wb_pc = '0; wb_ena = 1'b1; wb_reg = 5'd1;
      wb_value = '0; cfg_wr_only = 1'b0; cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
      cfg_trig_pc = '0; arm = 1'b0; stop = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_state", state, 2'd0);
      chk("rst_count", count, 3'd0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_pc", out_pc, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: free capture, consumer always ready
      out_ready = 1'b1;
      pulse_arm();
      chk("t1_state", state, 2'd2);
      ev(32'h0, 1'b1, 5'd1, 32'h11);
      chk("t1_pc0", out_pc, 32'h0);
      chk("t1_cnt0", count, 3'd1);
      chk("t1_val0", out_value, 32'h11);
      ev(32'h4, 1'b1, 5'd1, 32'h22);
      chk("t1_pc1", out_pc, 32'h4);
      ev(32'h8, 1'b1, 5'd1, 32'h33);
      chk("t1_pc2", out_pc, 32'h8);
      tick();
      chk("t1_cnt_end", count, 3'd0);
      chk("t1_valid_end", out_valid, 1'b0);
      chk("t1_ovf", overflow, 1'b0);

      // 2: PC trigger at 0x10
      pulse_stop();
      out_ready = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 32'h10;
      pulse_arm();
      chk("t2_armed", state, 2'd1);
      for (int i = 0; i < 8; i++) ev(32'(4 * i), 1'b1, 5'd2, 32'(i));
      chk("t2_first", out_pc, 32'h10);
      chk("t2_cnt", count, 3'd4);
      chk("t2_state", state, 2'd2);
      chk("t2_ovf", overflow, 1'b0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t2_second", out_pc, 32'h14);
      chk("t2_cnt_pop", count, 3'd3);

      // 3: stop-on-full
      pulse_stop();
      chk("t3_stop_keep", count, 3'd3);
      cfg_trig_en = 1'b0; cfg_wrap = 1'b0;
      pulse_arm();
      chk("t3_flush", count, 3'd0);
      for (int i = 0; i < 6; i++) ev(32'h100 + 32'(4 * i), 1'b1, 5'd3, 32'(i));
      chk("t3_cnt", count, 3'd4);
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_state", state, 2'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_drain", out_pc, 32'h100 + 32'(4 * i));
         tick();
      end
      ev(32'h200, 1'b1, 5'd3, 32'h0);
      chk("t3_frozen_nopush", count, 3'd0);
      out_ready = 1'b0;

      // 4: overwrite oldest
      cfg_wrap = 1'b1;
      pulse_arm();
      chk("t4_ovf_clr", overflow, 1'b0);
      for (int i = 0; i < 6; i++) ev(32'(4 * i), 1'b1, 5'd4, 32'(i));
      chk("t4_cnt", count, 3'd4);
      chk("t4_ovf", overflow, 1'b1);
      chk("t4_state", state, 2'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t4_drain", out_pc, 32'h8 + 32'(4 * i));
         tick();
      end
      chk("t4_empty", count, 3'd0);
      out_ready = 1'b0;

      // 5: write-only filter
      cfg_wrap = 1'b0; cfg_wr_only = 1'b1;
      pulse_arm();
      ev(32'h40, 1'b0, 5'd7, 32'h1);
      ev(32'h44, 1'b1, 5'd0, 32'h2);
      ev(32'h48, 1'b1, 5'd5, 32'hDEAD);
      chk("t5_cnt", count, 3'd1);
      chk("t5_pc", out_pc, 32'h48);
      chk("t5_reg", out_reg, 5'd5);
      chk("t5_ena", out_ena, 1'b1);
      chk("t5_val", out_value, 32'hDEAD);

      // 6: full throughput streaming, then mid-stream reset
      cfg_wr_only = 1'b0;
      pulse_arm();
      for (int i = 0; i < 4; i++) ev(32'h200 + 32'(4 * i), 1'b1, 5'd6, 32'(i));
      chk("t6_full", count, 3'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         chk("t6_head", out_pc, 32'h200 + 32'(4 * k));
         chk("t6_cnt", count, 3'd4);
         ev(32'h210 + 32'(4 * k), 1'b1, 5'd6, 32'(k));
      end
      chk("t6_ovf", overflow, 1'b0);
      chk("t6_state", state, 2'd2);
      wb_have_inst = 1'b1; wb_pc = 32'h300;
      rst_n = 1'b0;
      tick();
      chk("t6_rst_state", state, 2'd0);
      chk("t6_rst_cnt", count, 3'd0);
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_ovf", overflow, 1'b0);
      chk("t6_rst_pc", out_pc, 32'h0);
      chk("t6_rst_val", out_value, 32'h0);
      wb_have_inst = 1'b0; rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
